maxpool_ctrl: RTL

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

---
 rtl/maxpool_ctrl_if.sv | 25 ++
 rtl/maxpool_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl_if.sv
// Handshake and line-buffer control bundle for maxpool_ctrl.
// master: the controller; slave: the surrounding datapath / upstream / downstream.
interface maxpool_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       lb_wr_en;
    logic [9:0] lb_addr;
    logic       win_load;
    logic       pool_fire;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, lb_wr_en, lb_addr, win_load, pool_fire, out_valid, busy, done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, lb_wr_en, lb_addr, win_load, pool_fire, out_valid, busy, done
    );
endinterface

// File: rtl/maxpool_ctrl.sv
// Max-pool frame controller: walks a WIDTH x WIDTH raster, strobes the window
// compare and fires one pooled result per STRIDE x STRIDE window.
// Optional feature: define MAXPOOL_CTRL_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module maxpool_ctrl #(
    parameter int unsigned STRIDE = 2,
    parameter int unsigned WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    maxpool_ctrl_if.master       bus
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);
    localparam int unsigned AW = 10;
    localparam int unsigned PW = 2;
    localparam logic [AW-1:0] LAST_POS = AW'(WIDTH - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;
    logic [PW-1:0] col_ph_q, col_ph_d;
    logic [PW-1:0] row_ph_q, row_ph_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready;
    logic          accept;
    logic          fire;

    // Handshake decode, next-state logic and raster counters.
    // Phase counters track col%STRIDE / row%STRIDE without a divider.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        col_ph_d    = col_ph_q;
        row_ph_d    = row_ph_q;
        out_valid_d = out_valid_q & ~bus.out_ready;

        // Reset overrides the handshake so no pixel is written in the reset cycle.
        in_ready = (state_q == S_RUN) & ~(out_valid_q & ~bus.out_ready) & ~reset;
        accept   = bus.in_valid & in_ready;
        fire     = accept & (col_ph_q == PH_LAST) & (row_ph_q == PH_LAST);

        if (fire) begin
            out_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    col_d    = '0;
                    row_d    = '0;
                    col_ph_d = '0;
                    row_ph_d = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    col_ph_d = (col_ph_q == PH_LAST) ? '0 : col_ph_q + PW'(1);
                    if (col_q == LAST_POS) begin
                        col_d    = '0;
                        row_ph_d = (row_ph_q == PH_LAST) ? '0 : row_ph_q + PW'(1);
                        if (row_q == LAST_POS) begin
                            // Last pixel: wrap row instead of running past WIDTH-1.
                            row_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + AW'(1);
                        end
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (~out_valid_q | bus.out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and result-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            col_ph_q    <= '0;
            row_ph_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_ph_q    <= col_ph_d;
            row_ph_q    <= row_ph_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Count completed frames; wraps naturally at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.lb_wr_en  = accept;
    assign bus.lb_addr   = col_q;
    assign bus.win_load  = accept;
    assign bus.pool_fire = fire;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
endmodule
